// File: rtl/lsu_sram_ctrl.sv
// EX-stage load/store controller: turns one memory op into a data-SRAM
// transaction over an addr_ok/data_ok split handshake and stalls the pipe until it completes.
module lsu_sram_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ls_valid,
    input  logic [3:0]       ls_op,
    input  logic [31:0]      ls_addr,
    input  logic [31:0]      ls_wdata,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [3:0]       data_sram_wen,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    output logic             stall_req,
    output logic             ls_done,
    output logic [31:0]      ls_rdata,
    output logic             ls_excp,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] OP_LW  = 4'b1111;
    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LBU = 4'b0010;
    localparam logic [3:0] OP_LH  = 4'b0011;
    localparam logic [3:0] OP_LHU = 4'b0100;
    localparam logic [3:0] OP_SB  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1011;
    localparam logic [3:0] OP_SW  = 4'b1110;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_cancel;
    logic             w_cancel_nxt;
    logic             r_wr;
    logic [3:0]       r_wen;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt;

    logic             w_legal;
    logic             w_is_store;
    logic             w_excp;
    logic             w_start;
    logic [3:0]       w_wen;
    logic [31:0]      w_wdata;

    // Decode the op: legality, store flag, misalignment
    always_comb begin
        w_legal    = 1'b0;
        w_is_store = 1'b0;
        w_excp     = 1'b0;
        case (ls_op)
            OP_LB, OP_LBU: begin
                w_legal = 1'b1;
            end
            OP_LW: begin
                w_legal = 1'b1;
                w_excp  = (ls_addr[1:0] != 2'b00);
            end
            OP_LH, OP_LHU: begin
                w_legal = 1'b1;
                w_excp  = ls_addr[0];
            end
            OP_SB: begin
                w_legal    = 1'b1;
                w_is_store = 1'b1;
            end
            OP_SH: begin
                w_legal    = 1'b1;
                w_is_store = 1'b1;
                w_excp     = ls_addr[0];
            end
            OP_SW: begin
                w_legal    = 1'b1;
                w_is_store = 1'b1;
                w_excp     = (ls_addr[1:0] != 2'b00);
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign ls_excp = ls_valid & w_excp;
    assign w_start = ls_valid & w_legal & ~w_excp & ~flush;

    // Store byte-lane enables and lane-replicated write data
    always_comb begin
        w_wen   = 4'b0000;
        w_wdata = ls_wdata;
        case (ls_op)
            OP_SB: begin
                w_wen   = 4'b0001 << ls_addr[1:0];
                w_wdata = {4{ls_wdata[7:0]}};
            end
            OP_SH: begin
                w_wen   = 4'b0011 << ls_addr[1:0];
                w_wdata = {2{ls_wdata[15:0]}};
            end
            OP_SW: begin
                w_wen   = 4'b1111;
                w_wdata = ls_wdata;
            end
            default: begin
                w_wen   = 4'b0000;
                w_wdata = ls_wdata;
            end
        endcase
    end

    // Transaction FSM; a flush after the request is accepted only cancels the result
    always_comb begin
        w_state_nxt  = r_state;
        w_cancel_nxt = r_cancel;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt  = ST_REQ;
                    w_cancel_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (data_sram_addr_ok) begin
                    w_state_nxt  = ST_WAIT;
                    w_cancel_nxt = flush;
                end else if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (data_sram_data_ok) begin
                    w_cancel_nxt = 1'b0;
                    if (r_cancel | flush) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_cancel_nxt = r_cancel | flush;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_cancel_nxt = 1'b0;
            end
        endcase
    end

    // State, cancel flag and returned load word
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cancel <= 1'b0;
            r_rdata  <= 32'h0000_0000;
        end else begin
            r_state  <= w_state_nxt;
            r_cancel <= w_cancel_nxt;
            if ((r_state == ST_WAIT) && data_sram_data_ok && !(r_cancel || flush)) begin
                r_rdata <= data_sram_rdata;
            end
        end
    end

    // Latch the request fields at start so EX may change underneath us
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr    <= 1'b0;
            r_wen   <= 4'b0000;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
        end else if ((r_state == ST_IDLE) && w_start) begin
            r_wr    <= w_is_store;
            r_wen   <= w_wen;
            r_addr  <= {ls_addr[31:2], 2'b00};
            r_wdata <= w_wdata;
        end
    end

    // Saturating stall-cycle counter, clear wins over increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (stall_req && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign data_sram_req   = (r_state == ST_REQ);
    assign data_sram_wr    = r_wr;
    assign data_sram_wen   = r_wen;
    assign data_sram_addr  = r_addr;
    assign data_sram_wdata = r_wdata;
    assign stall_req       = ((r_state == ST_IDLE) & w_start) | (r_state == ST_REQ) | (r_state == ST_WAIT);
    assign ls_done         = (r_state == ST_DONE);
    assign ls_rdata        = r_rdata;
    assign stall_cycles    = r_cnt;

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Directed bench for lsu_sram_ctrl: vector table for decode/lanes plus
// hand-written sequences for latency, flush, reset and counter saturation.
module tb_lsu_sram_ctrl;

    logic        clk;
    logic        resetn;
    logic        ls_valid;
    logic [3:0]  ls_op;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        flush;
    logic        clr_cnt;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        stall_req;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_excp;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    lsu_sram_ctrl #(.CNT_W(16)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ls_valid          (ls_valid),
        .ls_op             (ls_op),
        .ls_addr           (ls_addr),
        .ls_wdata          (ls_wdata),
        .flush             (flush),
        .clr_cnt           (clr_cnt),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_wen     (data_sram_wen),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .stall_req         (stall_req),
        .ls_done           (ls_done),
        .ls_rdata          (ls_rdata),
        .ls_excp           (ls_excp),
        .stall_cycles      (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_excp;
        logic        exp_start;
        logic        exp_wr;
        logic [3:0]  exp_wen;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //               op       addr          wdata        excp  start wr   wen      addr          wdata
        vecs[0]  = '{4'b1111, 32'h0000_1004, 32'h0,          1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_1004, 32'h0};
        vecs[1]  = '{4'b1001, 32'h0000_2003, 32'h0000_00A5,  1'b0, 1'b1, 1'b1, 4'b1000, 32'h0000_2000, 32'hA5A5_A5A5};
        vecs[2]  = '{4'b1011, 32'h0000_2002, 32'h0000_1234,  1'b0, 1'b1, 1'b1, 4'b1100, 32'h0000_2000, 32'h1234_1234};
        vecs[3]  = '{4'b0011, 32'h0000_3001, 32'h0,          1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[4]  = '{4'b1110, 32'h0000_3002, 32'h1111_2222,  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[5]  = '{4'b1110, 32'h0000_4008, 32'hCAFE_F00D,  1'b0, 1'b1, 1'b1, 4'b1111, 32'h0000_4008, 32'hCAFE_F00D};
        vecs[6]  = '{4'b1001, 32'h0000_5001, 32'h1234_563C,  1'b0, 1'b1, 1'b1, 4'b0010, 32'h0000_5000, 32'h3C3C_3C3C};
        vecs[7]  = '{4'b0010, 32'h0000_6003, 32'h0,          1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_6000, 32'h0};
        vecs[8]  = '{4'b0100, 32'h0000_7003, 32'h0,          1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[9]  = '{4'b0101, 32'h0000_0000, 32'h0,          1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0};
        vecs[10] = '{4'b1011, 32'h0000_8000, 32'hFFFF_BEEF,  1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000_8000, 32'hBEEF_BEEF};
        vecs[11] = '{4'b0001, 32'h0000_9002, 32'h0,          1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_9000, 32'h0};

        resetn = 1'b0; ls_valid = 1'b0; ls_op = 4'b0000; ls_addr = 32'h0; ls_wdata = 32'h0;
        flush = 1'b0; clr_cnt = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        repeat (2) tick();
        chk("rst_req", {31'h0, data_sram_req}, 32'h0);
        chk("rst_stall", {31'h0, stall_req}, 32'h0);
        chk("rst_cnt", {16'h0, stall_cycles}, 32'h0);
        resetn = 1'b1;

        // Zero-wait LW
        tick();
        ls_valid = 1'b1; ls_op = 4'b1111; ls_addr = 32'h0000_1004; #1;
        chk("lw_idle_stall", {31'h0, stall_req}, 32'h1);
        chk("lw_idle_req", {31'h0, data_sram_req}, 32'h0);
        tick(); #1;
        chk("lw_req", {31'h0, data_sram_req}, 32'h1);
        chk("lw_wen", {28'h0, data_sram_wen}, 32'h0);
        chk("lw_addr", data_sram_addr, 32'h0000_1004);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; #1;
        chk("lw_wait_req", {31'h0, data_sram_req}, 32'h0);
        chk("lw_wait_stall", {31'h0, stall_req}, 32'h1);
        tick();
        data_sram_data_ok = 1'b0; ls_valid = 1'b0; #1;
        chk("lw_done", {31'h0, ls_done}, 32'h1);
        chk("lw_done_stall", {31'h0, stall_req}, 32'h0);
        chk("lw_rdata", ls_rdata, 32'hDEAD_BEEF);
        chk("lw_cnt", {16'h0, stall_cycles}, 32'd3);
        tick(); #1;
        chk("lw_done_pulse", {31'h0, ls_done}, 32'h0);

        // Decode / lane table
        for (int i = 0; i < 12; i++) begin
            tick();
            ls_valid = 1'b1; ls_op = vecs[i].op; ls_addr = vecs[i].addr; ls_wdata = vecs[i].wdata; #1;
            chk($sformatf("v%0d_excp", i), {31'h0, ls_excp}, {31'h0, vecs[i].exp_excp});
            chk($sformatf("v%0d_stall", i), {31'h0, stall_req}, {31'h0, vecs[i].exp_start});
            if (vecs[i].exp_start) begin
                tick(); #1;
                chk($sformatf("v%0d_req", i), {31'h0, data_sram_req}, 32'h1);
                chk($sformatf("v%0d_wr", i), {31'h0, data_sram_wr}, {31'h0, vecs[i].exp_wr});
                chk($sformatf("v%0d_wen", i), {28'h0, data_sram_wen}, {28'h0, vecs[i].exp_wen});
                chk($sformatf("v%0d_addr", i), data_sram_addr, vecs[i].exp_addr);
                if (vecs[i].exp_wr) chk($sformatf("v%0d_wdata", i), data_sram_wdata, vecs[i].exp_wdata);
                data_sram_addr_ok = 1'b1;
                tick();
                data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hA000_0000 | i;
                tick();
                data_sram_data_ok = 1'b0; ls_valid = 1'b0; #1;
                chk($sformatf("v%0d_done", i), {31'h0, ls_done}, 32'h1);
                if (!vecs[i].exp_wr) chk($sformatf("v%0d_rdata", i), ls_rdata, 32'hA000_0000 | i);
            end else begin
                tick(); #1;
                chk($sformatf("v%0d_noreq", i), {31'h0, data_sram_req}, 32'h0);
                chk($sformatf("v%0d_nostall", i), {31'h0, stall_req}, 32'h0);
                ls_valid = 1'b0;
                tick(); #1;
                chk($sformatf("v%0d_nodone", i), {31'h0, ls_done}, 32'h0);
            end
        end

        // Flush while addr_ok is withheld
        tick();
        ls_valid = 1'b1; ls_op = 4'b1110; ls_addr = 32'h0000_A000; ls_wdata = 32'h5555_AAAA;
        tick(); #1;
        chk("fl_req1", {31'h0, data_sram_req}, 32'h1);
        tick(); #1;
        chk("fl_req2", {31'h0, data_sram_req}, 32'h1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; ls_valid = 1'b0; #1;
        chk("fl_req_drop", {31'h0, data_sram_req}, 32'h0);
        chk("fl_stall_drop", {31'h0, stall_req}, 32'h0);
        chk("fl_nodone", {31'h0, ls_done}, 32'h0);
        tick(); #1;
        chk("fl_nodone2", {31'h0, ls_done}, 32'h0);

        // Flush coincident with addr_ok
        tick();
        ls_valid = 1'b1; ls_op = 4'b1111; ls_addr = 32'h0000_B000;
        tick();
        flush = 1'b1; data_sram_addr_ok = 1'b1;
        tick();
        flush = 1'b0; data_sram_addr_ok = 1'b0; ls_valid = 1'b0; #1;
        chk("fc_wait_req", {31'h0, data_sram_req}, 32'h0);
        chk("fc_wait_stall", {31'h0, stall_req}, 32'h1);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777; #1;
        chk("fc_dok_stall", {31'h0, stall_req}, 32'h1);
        tick();
        data_sram_data_ok = 1'b0; #1;
        chk("fc_nodone", {31'h0, ls_done}, 32'h0);
        chk("fc_stall_low", {31'h0, stall_req}, 32'h0);

        // Reset in the middle of WAIT
        tick();
        ls_valid = 1'b1; ls_op = 4'b0001; ls_addr = 32'h0000_C001;
        tick();
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0; ls_valid = 1'b0;
        tick();
        resetn = 1'b0; #1;
        chk("mr_req", {31'h0, data_sram_req}, 32'h0);
        chk("mr_addr", data_sram_addr, 32'h0);
        chk("mr_wen_wr", {27'h0, data_sram_wr, data_sram_wen}, 32'h0);
        chk("mr_wdata", data_sram_wdata, 32'h0);
        chk("mr_stall", {31'h0, stall_req}, 32'h0);
        chk("mr_rdata", ls_rdata, 32'h0);
        chk("mr_cnt", {16'h0, stall_cycles}, 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        tick();
        data_sram_data_ok = 1'b0; #1;
        chk("mr_nodone", {31'h0, ls_done}, 32'h0);
        chk("mr_rdata2", ls_rdata, 32'h0);
        chk("mr_stall2", {31'h0, stall_req}, 32'h0);

        // Counter saturation and clear priority, held in WAIT
        tick();
        ls_valid = 1'b1; ls_op = 4'b1111; ls_addr = 32'h0000_0100;
        tick();
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        repeat (65532) tick();
        #1;
        chk("sat_fffe", {16'h0, stall_cycles}, 32'h0000_FFFE);
        repeat (3) tick();
        #1;
        chk("sat_ffff", {16'h0, stall_cycles}, 32'h0000_FFFF);
        chk("sat_stall", {31'h0, stall_req}, 32'h1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0; #1;
        chk("clr_cnt", {16'h0, stall_cycles}, 32'h0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
        tick();
        data_sram_data_ok = 1'b0; ls_valid = 1'b0; #1;
        chk("sat_done", {31'h0, ls_done}, 32'h1);
        chk("sat_rdata", ls_rdata, 32'h0BAD_F00D);
        chk("sat_cnt_after", {16'h0, stall_cycles}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
